// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, owner codes, wait counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam logic OWN_CORE   = 1'b0;
  localparam logic OWN_DMA    = 1'b1;
  localparam int   WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter; slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_done;
  logic [DW-1:0] core_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_done;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_done, core_rdata, dma_done, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_done, core_rdata, dma_done, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// arb_pick2: combinational core/DMA picker; round-robin on ties, or core-first when ARB_CORE_PRIORITY_EN is defined.
// Zero latency; no backpressure of its own, the caller only consults it while idle.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_owner = OWN_CORE;
    if (req_a && req_b) begin
`ifdef ARB_CORE_PRIORITY_EN
      grant_owner = OWN_CORE;
`else
      // Tie goes to whoever was not served last.
      grant_owner = (last == OWN_CORE) ? OWN_DMA : OWN_CORE;
`endif
    end else if (req_b) begin
      grant_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises core and DMA accesses onto one memory port (ARB_CORE_PRIORITY_EN: core wins ties).
// Latency: access cycles k+1..k+1+WAIT_STATES, done at k+2+WAIT_STATES; one IDLE bubble between accesses.
// Backpressure: the loser holds req; requests are sampled only in IDLE and latched fields cannot be aborted.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_STATES);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  grant_vld;
  logic                  grant_own;

  arb_pick2 u_pick (
    .req_a       (bus.core_req),
    .req_b       (bus.dma_req),
    .last        (last_q),
    .grant_valid (grant_vld),
    .grant_owner (grant_own)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      last_q  <= OWN_DMA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.core_done = 1'b0;
    bus.dma_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_own;
          last_d  = grant_own;
          we_d    = (grant_own == OWN_DMA) ? bus.dma_we    : bus.core_we;
          addr_d  = (grant_own == OWN_DMA) ? bus.dma_addr  : bus.core_addr;
          wdata_d = (grant_own == OWN_DMA) ? bus.dma_wdata : bus.core_wdata;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        cnt_d      = cnt_q + 4'd1;
        // Memory data is valid on the final access cycle only.
        if (cnt_q == LAST_CNT) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.core_done = (owner_q == OWN_CORE);
        bus.dma_done  = (owner_q == OWN_DMA);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = rdata_q;
  assign bus.dma_rdata  = rdata_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle datapath between two requesters: the core controller (instruction fetch and load/store) and a DMA/debug engine.
- Serializes accesses and inserts a parameterised number of memory wait states.
- Returns one done pulse, carrying read data for reads, to the requester that was served.
- Sits between the core FSM / DMA engine and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_STATES, 1, extra memory cycles per access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core requests an access; held until core_done.
- core_we  in  1  1=write, 0=read; stable while core_req is high.
- core_addr  in  AW  access address.
- core_wdata  in  DW  write data.
- core_done  out  1  one-cycle pulse: core access complete.
- core_rdata  out  DW  read data; valid only while core_done=1.
- dma_req, dma_we, dma_addr, dma_wdata, dma_done, dma_rdata  as core_*, for the DMA requester.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid on the last ACCESS cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - state=IDLE, all outputs 0, wait counter=0, rdata register=0.
  - last_owner=DMA, so the first tie goes to the core.
  - Async assertion mid-access aborts immediately: mem_en/mem_we drop with reset and no done is issued.
- State machine:
  - IDLE:
    - Sample core_req and dma_req.
    - If exactly one is high, grant it.
    - If both are high, grant the one that is not last_owner (round-robin).
    - On grant: latch owner, we, addr and wdata; last_owner<=owner; counter<=0; go to ACCESS.
    - If neither is high, stay in IDLE.
  - ACCESS:
    - mem_en=1; mem_we=latched we; mem_addr/mem_wdata driven from the latched values.
    - Counter increments each cycle.
    - When counter==WAIT_STATES: capture mem_rdata into rdata register; go to DONE.
    - ACCESS therefore lasts exactly WAIT_STATES+1 cycles.
  - DONE:
    - Owner's *_done=1 for exactly one cycle.
    - Both *_rdata ports are driven from the rdata register; they are meaningful only with the matching done.
    - Next state is unconditionally IDLE.
    - Requests are not sampled in DONE.
- Latency: request first seen high in IDLE cycle k gives mem_en in cycles k+1..k+1+WAIT_STATES and done in cycle k+2+WAIT_STATES.
- Back-to-back accesses: at least one IDLE bubble between accesses.
- Handshake rules:
  - The requester drops req on the edge that ends its done cycle, or keeps it high to request again.
  - Changing the request fields or dropping req before done is illegal. The arbiter ignores this and completes the latched access; no abort.
  - The losing requester simply waits with req held.
- Writes: done still pulses; rdata holds whatever mem_rdata was on the last cycle and must be ignored by the requester.
- Outside ACCESS: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their latched values.
- Counter is 4 bits and never wraps in legal use.

Optional Feature:
- Macro ARB_CORE_PRIORITY_EN.
- Defined: fixed priority. The core always wins when both request; last_owner is still updated but unused.
- Undefined: round-robin as specified above.
- Single-requester behaviour is identical in both cases.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10;
  - owner constants: OWN_CORE=1'b0, OWN_DMA=1'b1;
  - WAIT_CNT_W=4.
- One sub-module, arb_pick2: combinational two-input picker (req_a, req_b, last, out: grant_valid, grant_owner).
  - Holds the ARB_CORE_PRIORITY_EN switch so the top-level FSM is unchanged.

Test Plan:
- WAIT_STATES=1, core read addr 0x10 at cycle 0, mem_rdata=0xDEADBEEF -> mem_en cycles 1-2, mem_we=0, core_done=1 in cycle 3 only with core_rdata=0xDEADBEEF, dma_done stays 0.
- Both req high at cycle 0 right after reset -> core done cycle 3, IDLE cycle 4, DMA mem_en cycles 5-6, dma_done cycle 7.
- Both req held continuously for 4 grants -> order C,D,C,D; with ARB_CORE_PRIORITY_EN -> C,C,C,C and dma_done never pulses.
- DMA write addr 0x20 data 0x55 -> mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0x55 for 2 cycles, then dma_done pulse, mem_we=0 afterwards.
- Reset pulsed in the first ACCESS cycle of a core read -> mem_en=0 in the same cycle, no core_done, busy=0; next simultaneous request is granted to the core.
- WAIT_STATES=0, single DMA read -> mem_en cycle 1 only, dma_done cycle 2.
